// File: rtl/mul_issue_ctrl.sv
// Issue stage in front of the pipelined multiplier: accepts one RV32 M-group
// instruction, runs the multiplier under a timeout and returns the tagged result.
module mul_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter bit          ZERO_BYPASS    = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [4:0]  rd_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic [4:0]  resp_rd_o,
  output logic        resp_err_o,
  output logic        mul_clr_o,
  output logic        mul_en_o,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  output logic        mul_signed_a_o,
  output logic        mul_signed_b_o,
  output logic        mul_upper_o,
  input  logic [31:0] mul_result_i,
  input  logic        mul_done_i
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_RESP} state_e;

  // Both handshakes: a transfer happens on a rising edge where valid and ready
  // are both 1; a raised valid holds its payload stable until that transfer.
  state_e           state_q, state_d;
  logic [31:0]      a_q, a_d, b_q, b_d, data_q, data_d;
  logic [4:0]       rd_q, rd_d;
  logic             sa_q, sa_d, sb_q, sb_d, up_q, up_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic accept, legal, dec_sa, dec_sb, dec_up, zero_op, mul_busy, in_resp;

  always_comb begin
    legal   = (opcode_i == 7'b0110011) && (funct7_i == 7'b0000001) && !funct3_i[2];
    dec_sa  = (funct3_i[1:0] != 2'b11);
    dec_sb  = !funct3_i[1];
    dec_up  = (funct3_i[1:0] != 2'b00);
    zero_op = (rs1_i == 32'd0) || (rs2_i == 32'd0);
    accept  = req_valid_i && req_ready_o;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    up_d    = up_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d    = rs1_i;
          b_d    = rs2_i;
          rd_d   = rd_i;
          sa_d   = dec_sa;
          sb_d   = dec_sb;
          up_d   = dec_up;
          data_d = 32'd0;
          cnt_d  = '0;
          if (!legal) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (ZERO_BYPASS && zero_op) begin
            err_d   = 1'b0;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        // done takes priority over the timeout on the same cycle
        if (mul_done_i) begin
          data_d  = mul_result_i;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = 32'd0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rd_q    <= 5'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      up_q    <= 1'b0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      up_q    <= up_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand and response buses are forced to 0 outside the states that own them.
  always_comb begin
    mul_busy       = (state_q == S_CLEAR) || (state_q == S_RUN);
    in_resp        = (state_q == S_RESP);
    req_ready_o    = (state_q == S_IDLE) && !rst_i;
    mul_clr_o      = (state_q == S_CLEAR);
    mul_en_o       = (state_q == S_RUN);
    mul_a_o        = mul_busy ? a_q : 32'd0;
    mul_b_o        = mul_busy ? b_q : 32'd0;
    mul_signed_a_o = mul_busy && sa_q;
    mul_signed_b_o = mul_busy && sb_q;
    mul_upper_o    = mul_busy && up_q;
    resp_valid_o   = in_resp;
    resp_data_o    = in_resp ? data_q : 32'd0;
    resp_rd_o      = in_resp ? rd_q : 5'd0;
    resp_err_o     = in_resp && err_q;
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: transaction-level timeline model checked every cycle,
// a behavioural multiplier with programmable done delay, directed and random ops.
module tb_mul_issue_ctrl;

  localparam int T = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [31:0] rs1_i, rs2_i;
  logic [4:0]  rd_i;
  logic        resp_valid_o, resp_ready_i, resp_err_o;
  logic [31:0] resp_data_o;
  logic [4:0]  resp_rd_o;
  logic        mul_clr_o, mul_en_o, mul_signed_a_o, mul_signed_b_o, mul_upper_o;
  logic [31:0] mul_a_o, mul_b_o, mul_result_i;
  logic        mul_done_i;

  mul_issue_ctrl #(.TIMEOUT_CYCLES(T), .ZERO_BYPASS(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_rd_o(resp_rd_o), .resp_err_o(resp_err_o),
    .mul_clr_o(mul_clr_o), .mul_en_o(mul_en_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_signed_a_o(mul_signed_a_o), .mul_signed_b_o(mul_signed_b_o),
    .mul_upper_o(mul_upper_o), .mul_result_i(mul_result_i), .mul_done_i(mul_done_i)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] mulfun(input logic [31:0] a, input logic [31:0] b,
                                         input logic sa, input logic sb, input logic up);
    logic [63:0] ea, eb, p;
    ea = sa ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sb ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return up ? p[63:32] : p[31:0];
  endfunction

  // ---------------- multiplier model and response-side driver ----------------
  int m_delay = 7;
  bit m_never = 1'b0;
  int mcnt    = 0;
  int hold_left = 0;
  bit rr_rand = 1'b0;

  always @(posedge clk_i) begin
    #1;
    if (mul_clr_o) begin
      mcnt = 0;
      mul_done_i   = 1'($urandom_range(0, 1));
      mul_result_i = $urandom;
    end else if (mul_en_o) begin
      mul_done_i   = !m_never && (mcnt >= m_delay);
      mul_result_i = mul_done_i ? mulfun(mul_a_o, mul_b_o, mul_signed_a_o, mul_signed_b_o,
                                         mul_upper_o) : $urandom;
      mcnt++;
    end else begin
      mul_done_i   = 1'($urandom_range(0, 1));
      mul_result_i = $urandom;
    end
    if (resp_valid_o && hold_left > 0) begin
      resp_ready_i = 1'b0;
      hold_left--;
    end else begin
      resp_ready_i = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  bit          busy = 1'b0;
  bit          is_mul;
  int          t0, resp_first;
  logic [31:0] m_a, m_b, m_data;
  logic [4:0]  m_rd;
  logic        m_err;
  logic [2:0]  m_flags;

  int          acc_cyc, first_rv, rv_cycles;
  bit          saw_clr, saw_en;
  logic [31:0] rv_data;
  logic [4:0]  rv_rd;
  logic        rv_err;
  logic [2:0]  cap_flags;

  always @(negedge clk_i) begin
    logic        e_ready, e_clr, e_en, e_rv, e_err;
    logic [31:0] e_a, e_b, e_data;
    logic [4:0]  e_rd;
    logic [2:0]  e_fl;
    int          run_len;
    e_ready = 1'b0; e_clr = 1'b0; e_en = 1'b0; e_rv = 1'b0; e_err = 1'b0;
    e_a = '0; e_b = '0; e_data = '0; e_rd = '0; e_fl = '0;
    if (!rst_i && !busy) e_ready = 1'b1;
    if (!rst_i && busy) begin
      if (is_mul && cyc < resp_first) begin
        e_clr = (cyc == t0 + 1);
        e_en  = (cyc >= t0 + 2);
        e_a   = m_a;
        e_b   = m_b;
        e_fl  = m_flags;
      end
      if (cyc >= resp_first) begin
        e_rv = 1'b1; e_data = m_data; e_rd = m_rd; e_err = m_err;
      end
    end
    chk("req_ready", {31'd0, req_ready_o}, {31'd0, e_ready});
    if (!rst_i) begin
      chk("mul_clr", {31'd0, mul_clr_o}, {31'd0, e_clr});
      chk("mul_en", {31'd0, mul_en_o}, {31'd0, e_en});
      chk("mul_a", mul_a_o, e_a);
      chk("mul_b", mul_b_o, e_b);
      chk("mul_flags", {29'd0, mul_signed_a_o, mul_signed_b_o, mul_upper_o}, {29'd0, e_fl});
      chk("resp_valid", {31'd0, resp_valid_o}, {31'd0, e_rv});
      chk("resp_data", resp_data_o, e_data);
      chk("resp_rd", {27'd0, resp_rd_o}, {27'd0, e_rd});
      chk("resp_err", {31'd0, resp_err_o}, {31'd0, e_err});
    end

    // observation record for the directed literal checks
    if (mul_clr_o) begin
      saw_clr = 1'b1;
      cap_flags = {mul_signed_a_o, mul_signed_b_o, mul_upper_o};
    end
    if (mul_en_o) saw_en = 1'b1;
    if (resp_valid_o) begin
      rv_cycles++;
      if (first_rv < 0) begin
        first_rv = cyc; rv_data = resp_data_o; rv_rd = resp_rd_o; rv_err = resp_err_o;
      end
    end

    if (rst_i) begin
      busy = 1'b0;
    end else if (!busy && req_valid_i) begin
      busy = 1'b1; t0 = cyc; m_a = rs1_i; m_b = rs2_i; m_rd = rd_i;
      acc_cyc = cyc; first_rv = -1; rv_cycles = 0; saw_clr = 1'b0; saw_en = 1'b0;
      cap_flags = 3'b000;
      case (funct3_i[1:0])
        2'b00:   m_flags = 3'b110;
        2'b01:   m_flags = 3'b111;
        2'b10:   m_flags = 3'b101;
        default: m_flags = 3'b001;
      endcase
      is_mul = 1'b0;
      if (opcode_i != 7'h33 || funct7_i != 7'h01 || funct3_i[2]) begin
        resp_first = cyc + 1; m_data = '0; m_err = 1'b1;
      end else if (rs1_i == 32'd0 || rs2_i == 32'd0) begin
        resp_first = cyc + 1; m_data = '0; m_err = 1'b0;
      end else begin
        is_mul  = 1'b1;
        run_len = (m_never || m_delay > T - 1) ? T : m_delay + 1;
        resp_first = cyc + 2 + run_len;
        if (!m_never && m_delay <= T - 1) begin
          m_data = mulfun(rs1_i, rs2_i, m_flags[2], m_flags[1], m_flags[0]);
          m_err  = 1'b0;
        end else begin
          m_data = '0; m_err = 1'b1;
        end
      end
    end else if (busy && cyc >= resp_first && resp_ready_i) begin
      busy = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic randomize_req();
    opcode_i = 7'($urandom); funct3_i = 3'($urandom); funct7_i = 7'($urandom);
    rs1_i = $urandom; rs2_i = $urandom; rd_i = 5'($urandom);
  endtask

  task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input int d, input bit nev, input int rst_after);
    bit ok;
    m_delay = d; m_never = nev;
    @(posedge clk_i); #1;
    req_valid_i = 1'b1; opcode_i = op; funct3_i = f3; funct7_i = f7;
    rs1_i = a; rs2_i = b; rd_i = rd;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_i);
      if (busy) begin ok = 1'b1; break; end
    end
    #1;
    req_valid_i = 1'b0;
    randomize_req();
    chk("accept_timeout", {31'd0, ok}, 32'd1);
    if (rst_after > 0) begin
      repeat (rst_after) @(posedge clk_i);
      #1 rst_i = 1'b1;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_i);
      if (!busy) begin ok = 1'b1; break; end
    end
    chk("done_timeout", {31'd0, ok}, 32'd1);
  endtask

  localparam logic [31:0] OPA = 32'h8000_0001;
  localparam logic [31:0] OPB = 32'h8001_0002;

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] exp_data [4];
    logic [2:0]  exp_flags [4];
    exp_data[0] = 32'h8001_0002; exp_data[1] = 32'h3FFF_7FFE;
    exp_data[2] = 32'hBFFF_7FFF; exp_data[3] = 32'h4000_8001;
    exp_flags[0] = 3'b110; exp_flags[1] = 3'b111; exp_flags[2] = 3'b101; exp_flags[3] = 3'b001;

    rst_i = 1'b1; req_valid_i = 1'b0; randomize_req();
    mul_done_i = 1'b0; mul_result_i = '0; resp_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_outs", {resp_valid_o, resp_err_o, mul_clr_o, mul_en_o, resp_rd_o}, 32'd0);

    // model arithmetic pinned to hand-computed products
    for (int k = 0; k < 4; k++)
      chk("pin_model", mulfun(OPA, OPB, exp_flags[k][2], exp_flags[k][1], exp_flags[k][0]),
          exp_data[k]);

    // the four multiply flavours with done 7 cycles after enable
    for (int k = 0; k < 4; k++) begin
      do_op(7'h33, 3'(k), 7'h01, OPA, OPB, 5'd5, 7, 1'b0, 0);
      chk("dir_latency", 32'(first_rv - acc_cyc), 32'd10);
      chk("dir_data", rv_data, exp_data[k]);
      chk("dir_rd_err", {26'd0, rv_rd, rv_err}, {26'd0, 5'd5, 1'b0});
      chk("dir_flags", {29'd0, cap_flags}, {29'd0, exp_flags[k]});
      chk("dir_clr_seen", {31'd0, saw_clr}, 32'd1);
    end

    // zero-operand bypass
    do_op(7'h33, 3'b011, 7'h01, 32'd0, 32'hFFFF_FFFF, 5'd9, 7, 1'b0, 0);
    chk("byp_latency", 32'(first_rv - acc_cyc), 32'd1);
    chk("byp_resp", {rv_data[30:0], rv_err}, 32'd0);
    chk("byp_mul_idle", {30'd0, saw_clr, saw_en}, 32'd0);

    // DIV is illegal
    do_op(7'h33, 3'b100, 7'h01, OPA, OPB, 5'd3, 7, 1'b0, 0);
    chk("ill_latency", 32'(first_rv - acc_cyc), 32'd1);
    chk("ill_resp", {rv_data, rv_err} == {32'd0, 1'b1} ? 32'd1 : 32'd0, 32'd1);
    chk("ill_mul_idle", {30'd0, saw_clr, saw_en}, 32'd0);

    // never done: timeout after 16 RUN cycles
    do_op(7'h33, 3'b000, 7'h01, OPA, OPB, 5'd7, 7, 1'b1, 0);
    chk("to_latency", 32'(first_rv - acc_cyc), 32'd18);
    chk("to_err", {31'd0, rv_err}, 32'd1);

    // done on the final RUN cycle wins over the timeout
    do_op(7'h33, 3'b001, 7'h01, OPA, OPB, 5'd8, T - 1, 1'b0, 0);
    chk("last_latency", 32'(first_rv - acc_cyc), 32'd18);
    chk("last_data", rv_data, 32'h3FFF_7FFE);
    chk("last_err", {31'd0, rv_err}, 32'd0);

    // response backpressure
    hold_left = 5;
    do_op(7'h33, 3'b011, 7'h01, OPA, OPB, 5'd12, 7, 1'b0, 0);
    chk("bp_valid_cycles", 32'(rv_cycles), 32'd6);
    chk("bp_data", rv_data, 32'h4000_8001);

    // reset in RUN drops the op, then a normal op follows
    do_op(7'h33, 3'b000, 7'h01, OPA, OPB, 5'd4, 7, 1'b0, 3);
    chk("rst_no_resp", 32'(first_rv), 32'hFFFF_FFFF);
    do_op(7'h33, 3'b000, 7'h01, OPA, OPB, 5'd4, 7, 1'b0, 0);
    chk("post_rst_data", rv_data, 32'h8001_0002);
    chk("post_rst_latency", 32'(first_rv - acc_cyc), 32'd10);

    // randomized traffic
    rr_rand = 1'b1;
    for (int n = 0; n < 200; n++) begin
      logic [6:0]  op, f7;
      logic [31:0] a, b;
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'h33;
      f7 = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'h01;
      a  = ($urandom_range(0, 6) == 0) ? 32'd0 : $urandom;
      b  = ($urandom_range(0, 6) == 0) ? 32'd0 : $urandom;
      do_op(op, 3'($urandom), f7, a, b, 5'($urandom), $urandom_range(0, 18),
            ($urandom_range(0, 12) == 0),
            ($urandom_range(0, 19) == 0) ? $urandom_range(1, 6) : 0);
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
    end

    repeat (3) @(posedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- Issue/sequencing stage directly upstream of the pipelined multiplier `multiplier_top_V6`.
- Accepts one RV32 instruction plus its register operands from the core over a valid/ready handshake, then decodes the M-extension multiply group.
- Clears and starts the multiplier, waits for its done flag under a timeout, and returns the 32-bit result tagged with rd over a second valid/ready handshake.
- Zero-operand multiplies and non-multiply instructions are answered without using the multiplier.

Parameters:
- TIMEOUT_CYCLES, 16: maximum RUN cycles before an error response is issued; must be > 1.
- ZERO_BYPASS, 1: when 1, a multiply with rs1==0 or rs2==0 responds with 0 without using the multiplier.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- req_valid_i  in  1  instruction request valid.
- req_ready_o  out  1  block can accept a request.
- opcode_i  in  7  instruction opcode.
- funct3_i  in  3  instruction funct3.
- funct7_i  in  7  instruction funct7.
- rs1_i  in  32  operand A.
- rs2_i  in  32  operand B.
- rd_i  in  5  destination register tag.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  core accepts response.
- resp_data_o  out  32  result.
- resp_rd_o  out  5  echoed rd tag.
- resp_err_o  out  1  response is an error (illegal op or timeout); data is 0.
- mul_clr_o  out  1  one-cycle clear pulse to the multiplier.
- mul_en_o  out  1  multiplier enable.
- mul_a_o  out  32  multiplier op_A.
- mul_b_o  out  32  multiplier op_B.
- mul_signed_a_o  out  1  multiplier signed_A.
- mul_signed_b_o  out  1  multiplier signed_B.
- mul_upper_o  out  1  multiplier upper.
- mul_result_i  in  32  multiplier result.
- mul_done_i  in  1  multiplier done.

Behaviour:
- Reset (any state, including mid-operation):
  - State goes to IDLE; any in-flight op is dropped and no response is produced for it.
  - All outputs are 0 except req_ready_o, which is 0 during reset and 1 in the first IDLE cycle after it.
  - Timeout counter is cleared.
- Decode (registered at accept):
  - Legal only when opcode==0110011, funct7==0000001, funct3[2]==0.
  - funct3 000 MUL: sA=1, sB=1, upper=0.
  - funct3 001 MULH: sA=1, sB=1, upper=1.
  - funct3 010 MULHSU: sA=1, sB=0, upper=1.
  - funct3 011 MULHU: sA=0, sB=0, upper=1.
  - Anything else (including DIV/REM funct3[2]=1) is illegal.
- FSM states: IDLE, CLEAR, RUN, RESP.
- IDLE:
  - req_ready_o=1. Accept occurs on req_valid_i && req_ready_o.
  - On accept, rs1, rs2, rd and the decoded controls are latched.
  - Illegal op: go to RESP with err=1, data=0.
  - Legal op with ZERO_BYPASS=1 and a zero operand: go to RESP with err=0, data=0.
  - Otherwise: go to CLEAR.
- CLEAR (1 cycle):
  - mul_clr_o=1, mul_en_o=0.
  - mul_a/b/signed/upper are driven from the latched values and held constant through RUN.
  - Next state is RUN.
- RUN:
  - mul_en_o=1; the counter increments every cycle.
  - If mul_done_i=1: capture mul_result_i into resp_data_o, set err=0, go to RESP.
  - Else if the counter reaches TIMEOUT_CYCLES-1: set err=1, data=0, go to RESP.
  - If done and the timeout limit coincide, done wins.
- RESP:
  - resp_valid_o=1; data, rd and err are held stable; mul_en_o=0.
  - On resp_ready_i=1, go to IDLE and drop resp_valid_o in the next cycle.
  - resp_valid_o never deasserts without a handshake.
- req_ready_o is 0 outside IDLE, so there is no overlap. Throughput is one op per (latency + handshake) cycles.
- mul_done_i outside RUN is ignored.
- Latency (accept at cycle 0, resp_ready_i held 1):
  - Bypass or illegal: resp_valid_o at cycle 1.
  - Multiplier path: clr at cycle 1, en from cycle 2; resp_valid_o the cycle after mul_done_i.
- Inputs from the request side are sampled only on the accept edge; later changes have no effect.

Test Plan:
- Bench multiplier model asserts done 7 cycles after en rises.
  - MUL, rs1=0x80000001, rs2=0x80010002, rd=5 -> clr pulse at cycle 1.
  - Expect resp_data_o=0x80010002, resp_rd_o=5, err=0, resp_valid_o at cycle 10.
- Same operands:
  - MULH -> 0x3FFF7FFE.
  - MULHSU -> 0xBFFF7FFF.
  - MULHU -> 0x40008001.
  - Check mul_signed_a/b/upper = 11/1, 10/1, 00/1 respectively.
- MULHU, rs1=0, rs2=0xFFFFFFFF, ZERO_BYPASS=1 -> resp_valid_o at cycle 1, data 0, mul_clr_o and mul_en_o never asserted.
- funct3=100 (DIV), opcode and funct7 valid -> err=1, data=0 at cycle 1, multiplier untouched.
- Model never asserts done -> err=1 after 16 RUN cycles, mul_en_o drops in RESP.
- Additional timeout case: done asserted on the final RUN cycle -> normal result, err=0.
- Backpressure and reset:
  - Hold resp_ready_i=0 for 5 cycles -> resp_valid/data/rd stable and req_ready_o=0 throughout.
  - Pulse rst_i during RUN -> all outputs 0 next cycle, IDLE, no response emitted, next op completes normally.
